// File: rtl/mon_queue_writer.sv
// Monitoring record writer: streams NI monitor records into a slot ring in data memory
// and maintains the available/occupied slot semaphores shared with the CPU.
module mon_queue_writer #(
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mon_reset_i,
    input  logic                  mon_sem_av_post_i,
    input  logic                  mon_sem_oc_wait_i,
    input  logic [7:0]            mon_sem_av_i,
    input  logic [7:0]            mon_flits_i,
    input  logic [31:0]           mon_addr_i,
    output logic [7:0]            mon_sem_oc_o,
    output logic                  mon_active_o,
    output logic [DROP_CNT_W-1:0] mon_drop_cnt_o,
    input  logic                  rec_valid_i,
    output logic                  rec_ready_o,
    input  logic [31:0]           rec_data_i,
    input  logic                  rec_last_i,
    output logic                  mem_en_o,
    output logic [3:0]            mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic                  mem_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DROP   = 2'd3
    } state_e;

    state_e                state_q;
    logic [7:0]            slots_q, flits_q, av_q, oc_q, wr_slot_q, idx_q;
    logic [31:0]           base_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    logic                  ring_en_s, in_range_s, beat_acc_s, commit_s;
    logic [15:0]           slot_off_s;
    logic [16:0]           word_off_s;
    logic [7:0]            av_m_s, av_d, oc_d;

    // Memory request, handshake and ring addressing for the current beat
    always_comb begin
        ring_en_s  = (slots_q != 8'd0) && (flits_q != 8'd0);
        in_range_s = (idx_q < flits_q);
        slot_off_s = {8'd0, wr_slot_q} * {8'd0, flits_q};
        word_off_s = {1'b0, slot_off_s} + {9'd0, idx_q};
        mem_addr_o = base_q + {13'd0, word_off_s, 2'b00};
        mem_data_o = rec_data_i;
        mem_en_o   = (state_q == ST_WRITE) && rec_valid_i && in_range_s;
        mem_we_o   = mem_en_o ? 4'hF : 4'h0;
        case (state_q)
            ST_WRITE: rec_ready_o = (mem_en_o && mem_ready_i) || (rec_valid_i && !in_range_s);
            ST_DROP:  rec_ready_o = 1'b1;
            default:  rec_ready_o = 1'b0;
        endcase
        beat_acc_s = rec_valid_i && rec_ready_o;
    end

    // Semaphore next values; a post that would exceed the ring size is ignored
    always_comb begin
        commit_s = (state_q == ST_COMMIT);
        av_m_s   = av_q - {7'd0, commit_s};
        if (mon_sem_av_post_i && (av_m_s < slots_q)) begin
            av_d = av_m_s + 8'd1;
        end else begin
            av_d = av_m_s;
        end
        if (commit_s && mon_sem_oc_wait_i) begin
            oc_d = oc_q;
        end else if (commit_s) begin
            oc_d = (oc_q == 8'hFF) ? oc_q : oc_q + 8'd1;
        end else if (mon_sem_oc_wait_i && (oc_q != 8'd0)) begin
            oc_d = oc_q - 8'd1;
        end else begin
            oc_d = oc_q;
        end
    end

    // Record FSM, ring configuration and semaphore state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            slots_q    <= 8'd0;
            flits_q    <= 8'd0;
            base_q     <= 32'd0;
            av_q       <= 8'd0;
            oc_q       <= 8'd0;
            wr_slot_q  <= 8'd0;
            idx_q      <= 8'd0;
            drop_cnt_q <= '0;
        end else if (mon_reset_i) begin
            slots_q   <= mon_sem_av_i;
            av_q      <= mon_sem_av_i;
            flits_q   <= mon_flits_i;
            base_q    <= mon_addr_i;
            oc_q      <= 8'd0;
            wr_slot_q <= 8'd0;
            idx_q     <= 8'd0;
            // An interrupted record drains through DROP so its tail is not mistaken for a new record
            if (((state_q == ST_WRITE) || (state_q == ST_DROP)) && !(beat_acc_s && rec_last_i)) begin
                state_q <= ST_DROP;
            end else begin
                state_q <= ST_IDLE;
            end
        end else begin
            av_q <= av_d;
            oc_q <= oc_d;
            case (state_q)
                ST_IDLE: begin
                    if (rec_valid_i) begin
                        idx_q <= 8'd0;
                        if ((av_q != 8'd0) && ring_en_s) begin
                            state_q <= ST_WRITE;
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (beat_acc_s) begin
                        idx_q <= (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;
                        state_q <= rec_last_i ? ST_COMMIT : ST_WRITE;
                    end else begin
                        state_q <= ST_WRITE;
                    end
                end
                ST_COMMIT: begin
                    wr_slot_q <= (wr_slot_q == slots_q - 8'd1) ? 8'd0 : wr_slot_q + 8'd1;
                    state_q   <= ST_IDLE;
                end
                ST_DROP: begin
                    if (beat_acc_s && rec_last_i) begin
                        if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
                            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
                        end else begin
                            drop_cnt_q <= drop_cnt_q;
                        end
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DROP;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mon_sem_oc_o   = oc_q;
    assign mon_active_o   = (state_q != ST_IDLE);
    assign mon_drop_cnt_o = drop_cnt_q;

endmodule
